// File: rtl/sweep_timer_ctrl_if.sv
// Avalon-MM write-only master port toward the interval timer, plus the timer's
// level interrupt returned to the controller.
interface sweep_timer_ctrl_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic        timer_irq;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  timer_irq
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output timer_irq
    );
endinterface

// File: rtl/sweep_timer_ctrl.sv
// Sweep controller: programs an interval timer, counts its timeouts, emits one
// trig pulse per timeout and stops the timer after N events or on request.
module sweep_timer_ctrl #(
    parameter int TRIG_WIDTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          period,
    input  logic [CNT_W-1:0]     num_events,
    sweep_timer_ctrl_if.master   avm,
    output logic                 trig,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     event_count
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, GAP, WR_STOP, FIN
    } state_t;

    localparam logic [3:0]  TRIG_LOAD = 4'(TRIG_WIDTH);
    localparam logic [15:0] CTRL_RUN  = 16'h0007;
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    state_t            state, state_nxt;
    logic [31:0]       period_q;
    logic [CNT_W-1:0]  num_q;
    logic [3:0]        trig_cnt;
    logic [31:0]       load_val;
    logic              accept_start;
    logic              accept_irq;

    // Periods below 2 are clamped to a 2-cycle interval.
    assign load_val     = (period_q < 32'd2) ? 32'd1 : period_q - 32'd1;
    assign accept_start = (state == IDLE) && start && !stop;
    assign accept_irq   = (state == WAIT_IRQ) && avm.timer_irq && !stop;

    assign trig = (trig_cnt != 4'd0);
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= '0;
            num_q       <= '0;
            event_count <= '0;
            trig_cnt    <= '0;
        end else begin
            if (accept_start) begin
                period_q    <= period;
                num_q       <= num_events;
                event_count <= '0;
            end else if (accept_irq) begin
                event_count <= event_count + CNT_W'(1);
            end

            if (accept_irq) begin
                trig_cnt <= TRIG_LOAD;
            end else if (trig_cnt != 4'd0) begin
                trig_cnt <= trig_cnt - 4'd1;
            end
        end
    end

    // Write states last one cycle, so a stop seen during a write is carried
    // forward simply by choosing WR_STOP as the next state.
    always_comb begin
        state_nxt          = state;
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_address    = '0;
        avm.avm_writedata  = '0;
        unique case (state)
            IDLE: begin
                if (accept_start) state_nxt = WR_PL;
            end
            WR_PL: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd2;
                avm.avm_writedata  = load_val[15:0];
                state_nxt          = stop ? WR_STOP : WR_PH;
            end
            WR_PH: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd3;
                avm.avm_writedata  = load_val[31:16];
                state_nxt          = stop ? WR_STOP : WR_CTRL;
            end
            WR_CTRL: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd1;
                avm.avm_writedata  = CTRL_RUN;
                state_nxt          = stop ? WR_STOP : WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (stop)            state_nxt = WR_STOP;
                else if (accept_irq) state_nxt = CLR_ST;
            end
            CLR_ST: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                state_nxt          = stop ? WR_STOP : GAP;
            end
            GAP: begin
                if (stop || (num_q != '0 && event_count == num_q)) state_nxt = WR_STOP;
                else                                                state_nxt = WAIT_IRQ;
            end
            WR_STOP: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd1;
                avm.avm_writedata  = CTRL_STOP;
                state_nxt          = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sweep_timer_ctrl.md
SWEEP_TIMER_CTRL -- requirements
Module: sweep_timer_ctrl

Interface
REQ-001 Parameter TRIG_WIDTH, default 4: trig high time in clk cycles (legal 1..15).
REQ-002 Parameter CNT_W, default 16: width of num_events and event_count.
REQ-003 clk  in  1  single clock; all state rises on posedge clk.
REQ-004 reset_n  in  1  reset is asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a sweep.
REQ-006 stop  in  1  one-cycle request to abort a running sweep.
REQ-007 period  in  32  timeout interval in clk cycles; sampled on an accepted start.
REQ-008 num_events  in  CNT_W  timeouts per sweep; 0 = run until stop; sampled on an accepted start.
REQ-009 avm_address  out  3  timer register select: 0 status, 1 control, 2 period_l, 3 period_h.
REQ-010 avm_chipselect  out  1  timer access strobe.
REQ-011 avm_write_n  out  1  active-low write; the block never reads.
REQ-012 avm_writedata  out  16  timer write data.
REQ-013 timer_irq  in  1  timer interrupt, level, cleared by a status write.
REQ-014 trig  out  1  sweep trigger pulse, one per timeout.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at sweep end, normal or aborted.
REQ-017 event_count  out  CNT_W  timeouts serviced in the current or last sweep.

Function
REQ-018 States: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, GAP, WR_STOP, FIN.
REQ-019 Each WR_*/CLR_ST state lasts exactly one cycle with chipselect=1 and write_n=0; all other states drive chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 IDLE->WR_PL on start=1 and stop=0; event_count clears to 0 and period/num_events are latched.
REQ-021 Load value L = max(period,2)-1, so period values 0 and 1 both give a 2-cycle interval.
REQ-022 WR_PL writes L[15:0] to address 2; WR_PH writes L[31:16] to address 3; WR_CTRL writes 0x0007 (ITO|CONT|START) to address 1; then WAIT_IRQ.
REQ-023 WAIT_IRQ: on timer_irq=1 go to CLR_ST, increment event_count (wrapping modulo 2^CNT_W), and start trig.
REQ-024 CLR_ST writes 0x0000 to address 0; GAP is one idle cycle while the timer irq deasserts; timer_irq is ignored in GAP.
REQ-025 GAP->WR_STOP if num_events!=0 and event_count==num_events; otherwise GAP->WAIT_IRQ.
REQ-026 WR_STOP writes 0x0008 (STOP, ITO=0) to address 1, then FIN; FIN pulses done for one cycle, then IDLE.
REQ-027 trig rises the cycle after the irq is accepted and stays high TRIG_WIDTH cycles; a new acceptance while trig is high restarts the width count.
REQ-028 stop=1 in WAIT_IRQ or GAP goes directly to WR_STOP; the current access is not counted as a timeout.
REQ-029 stop=1 during WR_PL/WR_PH/WR_CTRL/CLR_ST is latched; the in-progress write completes and the next state is WR_STOP.
REQ-030 stop takes priority over timer_irq in the same cycle.
REQ-031 start while busy=1 is ignored; stop in IDLE is ignored; start and stop together in IDLE are ignored.
REQ-032 event_count holds its final value in IDLE until the next accepted start.

Reset
REQ-033 While reset_n=0: state=IDLE, chipselect=0, write_n=1, address=0, writedata=0, trig=0, busy=0, done=0, event_count=0, latched period/num_events/stop=0.
REQ-034 Reset asserted mid-sweep abandons the sweep with no stop write; the timer is reset by the same reset_n.

Verification
REQ-035 start, period=1000, num_events=3 -> writes (2,0x03E7),(3,0x0000),(1,0x0007); three irqs give trig each, status writes, event_count=3, then (1,0x0008) and done.
REQ-036 period=0x00012345 -> writedata 0x2344 at address 2, then 0x0001 at address 3.
REQ-037 period=1 -> L=1 written to address 2; period=0 -> identical writes.
REQ-038 num_events=0, stop after 5 irqs -> event_count=5, WR_STOP, done; no further trig.
REQ-039 stop during WR_PH -> WR_PH write completes, next cycle writes (1,0x0008), done; event_count=0.
REQ-040 start during WAIT_IRQ ignored; irq and stop in the same cycle -> no trig and event_count unchanged; reset_n low in WAIT_IRQ -> all outputs at REQ-033 values asynchronously.
